// File: rtl/fifo_arb_pkg.sv
// Shared definitions for FIFO port arbiters: state encoding, clog2 helper and
// default sizing constants.
package fifo_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    localparam int DEF_NREQ  = 4;
    localparam int DEF_BURST = 4;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/fifo_rd_arbiter_rr_pick.sv
// Rotating-priority picker: lowest set request at or above ptr, else wrap to
// the lowest set request overall. Output is one-hot or zero.
module rr_pick #(
    parameter int N  = 4,
    parameter int PW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  winner,
    output logic          any
);
    logic [N-1:0] upper_mask;
    logic [N-1:0] upper;
    logic [N-1:0] sel;

    // Bits at or above ptr; isolating the lowest set bit of the chosen vector
    // yields the winner without any variable indexing.
    assign upper_mask = ~((N'(1) << ptr) - N'(1));
    assign upper      = req & upper_mask;
    assign sel        = (|upper) ? upper : req;
    assign winner     = sel & (~sel + N'(1));
    assign any        = |req;

endmodule

// File: rtl/fifo_rd_arbiter.sv
// Read-side arbiter sharing one async-FIFO read port among NREQ consumers with
// BURST-bounded grants. Define FIFO_RD_ARB_FIXED_PRIO_EN for fixed priority.
module fifo_rd_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NREQ  = DEF_NREQ,
    parameter int DSIZE = 8,
    parameter int BURST = DEF_BURST
) (
    input  logic             rclk,
    input  logic             rrst,
    input  logic             rempty,
    input  logic [DSIZE-1:0] rdata,
    output logic             rinc,
    input  logic [NREQ-1:0]  req,
    input  logic [NREQ-1:0]  rd_ready,
    output logic [NREQ-1:0]  rd_valid,
    output logic [DSIZE-1:0] rd_data,
    output logic [NREQ-1:0]  gnt,
    output logic             busy
);
    localparam int CW = clog2(BURST) + 1;
    localparam int PW = (clog2(NREQ) > 0) ? clog2(NREQ) : 1;
    localparam logic [CW-1:0] LAST = CW'(BURST - 1);

    arb_state_t      state, state_nx;
    logic [NREQ-1:0] gnt_nx;
    logic [CW-1:0]   cnt, cnt_nx;
    logic [NREQ-1:0] pick;
    logic            pick_any;
    logic [PW-1:0]   pick_ptr;
    logic            xfer;
    logic            req_g;
    logic            rel;

`ifdef FIFO_RD_ARB_FIXED_PRIO_EN
    assign pick_ptr = '0;
`else
    logic [PW-1:0] rr_ptr, rr_ptr_nx, after_g;

    assign pick_ptr = rr_ptr;

    always_comb begin
        after_g = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt[i]) after_g = PW'((i + 1) % NREQ);
        end
    end
`endif

    rr_pick #(
        .N  (NREQ),
        .PW (PW)
    ) u_pick (
        .req    (req),
        .ptr    (pick_ptr),
        .winner (pick),
        .any    (pick_any)
    );

    assign busy     = (state == GRANT);
    assign xfer     = busy & ~rempty & (|(gnt & rd_ready));
    assign req_g    = |(gnt & req);
    assign rinc     = xfer;
    assign rd_valid = (busy && !rempty) ? gnt : '0;
    assign rd_data  = rdata;
    // A withdrawn request releases even if its final word moves this cycle.
    assign rel      = (xfer && (cnt == LAST)) || !req_g;

    always_comb begin
        state_nx  = state;
        gnt_nx    = gnt;
        cnt_nx    = cnt;
`ifndef FIFO_RD_ARB_FIXED_PRIO_EN
        rr_ptr_nx = rr_ptr;
`endif
        case (state)
            IDLE: begin
                if (pick_any) begin
                    state_nx = GRANT;
                    gnt_nx   = pick;
                    cnt_nx   = '0;
                end
            end
            GRANT: begin
                if (xfer) cnt_nx = cnt + CW'(1);
                if (rel) begin
                    state_nx  = IDLE;
                    gnt_nx    = '0;
                    cnt_nx    = '0;
`ifndef FIFO_RD_ARB_FIXED_PRIO_EN
                    rr_ptr_nx = after_g;
`endif
                end
            end
            default: begin
                state_nx = IDLE;
                gnt_nx   = '0;
                cnt_nx   = '0;
            end
        endcase
    end

    always_ff @(posedge rclk) begin
        if (rrst) begin
            state  <= IDLE;
            gnt    <= '0;
            cnt    <= '0;
`ifndef FIFO_RD_ARB_FIXED_PRIO_EN
            rr_ptr <= '0;
`endif
        end else begin
            state  <= state_nx;
            gnt    <= gnt_nx;
            cnt    <= cnt_nx;
`ifndef FIFO_RD_ARB_FIXED_PRIO_EN
            rr_ptr <= rr_ptr_nx;
`endif
        end
    end

endmodule

// File: tb/tb_fifo_rd_arbiter.sv
// Directed bench for fifo_rd_arbiter: cycle table plus FIFO-backed burst
// sequences (single requester and all requesters).
module tb_fifo_rd_arbiter;

    logic       clk;
    logic       rrst;
    logic       rempty;
    logic [7:0] rdata;
    logic       rinc;
    logic [3:0] req;
    logic [3:0] rd_ready;
    logic [3:0] rd_valid;
    logic [7:0] rd_data;
    logic [3:0] gnt;
    logic       busy;

    int total;
    int passed;

    fifo_rd_arbiter #(
        .NREQ  (4),
        .DSIZE (8),
        .BURST (4)
    ) dut (
        .rclk     (clk),
        .rrst     (rrst),
        .rempty   (rempty),
        .rdata    (rdata),
        .rinc     (rinc),
        .req      (req),
        .rd_ready (rd_ready),
        .rd_valid (rd_valid),
        .rd_data  (rd_data),
        .gnt      (gnt),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       rst;
        logic       empty;
        logic [3:0] rq;
        logic [3:0] rdy;
        logic       x_rinc;
        logic [3:0] x_valid;
        logic [3:0] x_gnt;
        logic       x_busy;
    } vec_t;

    localparam int NV = 23;
    vec_t tbl [NV];

    function automatic vec_t v(input logic r, input logic e, input logic [3:0] rq,
                               input logic [3:0] rdy, input logic ri,
                               input logic [3:0] vl, input logic [3:0] g,
                               input logic b);
        vec_t t;
        t.rst = r; t.empty = e; t.rq = rq; t.rdy = rdy;
        t.x_rinc = ri; t.x_valid = vl; t.x_gnt = g; t.x_busy = b;
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got === want) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, got, want);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rrst = 1'b1; req = '0; rd_ready = '0; rempty = 1'b1; rdata = '0;
        @(negedge clk);
        rrst = 1'b0;
    endtask

    logic [7:0] fq [$];
    logic [7:0] exp_word;
    int         order [5];

    initial begin
        rrst = 1'b1; req = '0; rd_ready = '0; rempty = 1'b1; rdata = '0;
        total = 0; passed = 0;

        //             rst empty req      rdy      rinc valid    gnt      busy
        tbl[0]  = v(0, 1, 4'b0000, 4'b0000, 0, 4'b0000, 4'b0000, 0);
        tbl[1]  = v(0, 0, 4'b0010, 4'b0010, 0, 4'b0000, 4'b0000, 0);
        tbl[2]  = v(0, 0, 4'b0010, 4'b0010, 1, 4'b0010, 4'b0010, 1);
        tbl[3]  = v(0, 0, 4'b0010, 4'b0010, 1, 4'b0010, 4'b0010, 1);
        tbl[4]  = v(0, 0, 4'b0010, 4'b0010, 1, 4'b0010, 4'b0010, 1);
        tbl[5]  = v(0, 0, 4'b0010, 4'b0010, 1, 4'b0010, 4'b0010, 1);
        tbl[6]  = v(0, 0, 4'b0010, 4'b0010, 0, 4'b0000, 4'b0000, 0);
        tbl[7]  = v(0, 1, 4'b0010, 4'b0010, 0, 4'b0000, 4'b0010, 1);
        tbl[8]  = v(0, 0, 4'b0010, 4'b0000, 0, 4'b0010, 4'b0010, 1);
        tbl[9]  = v(0, 0, 4'b0010, 4'b0010, 1, 4'b0010, 4'b0010, 1);
        tbl[10] = v(0, 0, 4'b0000, 4'b0010, 1, 4'b0010, 4'b0010, 1);
        tbl[11] = v(0, 0, 4'b1000, 4'b1000, 0, 4'b0000, 4'b0000, 0);
        tbl[12] = v(0, 0, 4'b1000, 4'b1000, 1, 4'b1000, 4'b1000, 1);
        tbl[13] = v(0, 0, 4'b0000, 4'b0000, 0, 4'b1000, 4'b1000, 1);
        tbl[14] = v(0, 0, 4'b0011, 4'b0000, 0, 4'b0000, 4'b0000, 0);
        tbl[15] = v(0, 0, 4'b0011, 4'b0001, 1, 4'b0001, 4'b0001, 1);
        tbl[16] = v(0, 0, 4'b0010, 4'b0000, 0, 4'b0001, 4'b0001, 1);
        tbl[17] = v(0, 0, 4'b0100, 4'b0000, 0, 4'b0000, 4'b0000, 0);
        tbl[18] = v(1, 0, 4'b0100, 4'b0100, 1, 4'b0100, 4'b0100, 1);
        tbl[19] = v(0, 0, 4'b0011, 4'b0000, 0, 4'b0000, 4'b0000, 0);
        tbl[20] = v(0, 1, 4'b0011, 4'b0000, 0, 4'b0000, 4'b0001, 1);
        tbl[21] = v(0, 1, 4'b0000, 4'b0000, 0, 4'b0000, 4'b0001, 1);
        tbl[22] = v(0, 1, 4'b0000, 4'b0000, 0, 4'b0000, 4'b0000, 0);

        do_reset();

        for (int i = 0; i < NV; i++) begin
            logic [7:0] d;
            @(negedge clk);
            d        = 8'(i * 37 + 5);
            rrst     = tbl[i].rst;
            rempty   = tbl[i].empty;
            req      = tbl[i].rq;
            rd_ready = tbl[i].rdy;
            rdata    = d;
            #1;
            chk($sformatf("vec%0d rinc", i), 32'(rinc), 32'(tbl[i].x_rinc));
            chk($sformatf("vec%0d rd_valid", i), 32'(rd_valid), 32'(tbl[i].x_valid));
            chk($sformatf("vec%0d gnt", i), 32'(gnt), 32'(tbl[i].x_gnt));
            chk($sformatf("vec%0d busy", i), 32'(busy), 32'(tbl[i].x_busy));
            chk($sformatf("vec%0d rd_data", i), 32'(rd_data), 32'(d));
        end

        // All four requesters, FIFO always non-empty: bursts of four with a
        // one-cycle bubble, rotating through the consumers.
        for (int s = 0; s < 5; s++) begin
`ifdef FIFO_RD_ARB_FIXED_PRIO_EN
            order[s] = 0;
`else
            order[s] = s % 4;
`endif
        end
        do_reset();
        fq.delete();
        for (int i = 0; i < 40; i++) fq.push_back(8'(8'h40 + i));
        exp_word = 8'h40;
        for (int k = 0; k < 25; k++) begin
            logic [3:0] eg;
            logic       er;
            @(negedge clk);
            req      = 4'b1111;
            rd_ready = 4'b1111;
            rempty   = (fq.size() == 0);
            rdata    = rempty ? 8'h00 : fq[0];
            #1;
            er = ((k % 5) != 0);
            eg = er ? 4'(1 << order[k / 5]) : 4'b0000;
            chk($sformatf("all cyc%0d gnt", k), 32'(gnt), 32'(eg));
            chk($sformatf("all cyc%0d rinc", k), 32'(rinc), 32'(er));
            chk($sformatf("all cyc%0d rd_valid", k), 32'(rd_valid), 32'(eg));
            if (er) begin
                chk($sformatf("all cyc%0d data", k), 32'(rd_data), 32'(exp_word));
                exp_word = exp_word + 8'd1;
            end
            if (rinc === 1'b1 && fq.size() > 0) void'(fq.pop_front());
        end

        // Single requester draining a 10-word FIFO: 4, bubble, 4, bubble, 2,
        // then the grant holds with nothing to pop.
        do_reset();
        fq.delete();
        for (int i = 0; i < 10; i++) fq.push_back(8'(8'hA0 + i));
        exp_word = 8'hA0;
        for (int k = 0; k < 16; k++) begin
            logic [3:0] eg;
            logic [3:0] ev;
            logic       er;
            @(negedge clk);
            req      = 4'b0010;
            rd_ready = 4'b1111;
            rempty   = (fq.size() == 0);
            rdata    = rempty ? 8'h00 : fq[0];
            #1;
            if (k >= 13) begin
                er = 1'b0; eg = 4'b0010; ev = 4'b0000;
            end else begin
                er = ((k % 5) != 0);
                eg = er ? 4'b0010 : 4'b0000;
                ev = eg;
            end
            chk($sformatf("one cyc%0d gnt", k), 32'(gnt), 32'(eg));
            chk($sformatf("one cyc%0d rinc", k), 32'(rinc), 32'(er));
            chk($sformatf("one cyc%0d rd_valid", k), 32'(rd_valid), 32'(ev));
            if (er) begin
                chk($sformatf("one cyc%0d data", k), 32'(rd_data), 32'(exp_word));
                exp_word = exp_word + 8'd1;
            end
            if (rinc === 1'b1 && fq.size() > 0) void'(fq.pop_front());
        end
        chk("one words left", 32'(fq.size()), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/fifo_rd_arbiter.md
Name: fifo_rd_arbiter

Overview:
- Shares the single read port of the async FIFO's read domain among NREQ consumers.
- Round-robin grants, each bounded to BURST words.
- Drives the FIFO pop strobe (rinc) from rempty and the granted consumer's ready.
- Sits entirely in the read clock domain, between the read-pointer/empty logic plus memory read data and the downstream consumers.

Parameters:
- NREQ, 4, number of requesting consumers (2..8)
- DSIZE, 8, FIFO data width
- BURST, 4, max words per grant (1..16)

Ports:
- rclk  input  1  read-domain clock
- rrst  input  1  reset, synchronous, active-high
- rempty  input  1  FIFO empty flag (registered, read domain)
- rdata  input  DSIZE  FIFO head word; valid whenever rempty=0 (fall-through read)
- rinc  output  1  FIFO pop strobe
- req  input  NREQ  per-consumer request, level
- rd_ready  input  NREQ  per-consumer accept
- rd_valid  output  NREQ  per-consumer data valid
- rd_data  output  DSIZE  shared data bus = rdata
- gnt  output  NREQ  one-hot current grant
- busy  output  1  high in GRANT state

Behaviour:
- Clock and reset: one clock, rclk. Reset rrst is synchronous, active-high. On an rrst edge: state=IDLE, gnt=0, cnt=0, rr_ptr=0, so rd_valid=0, rinc=0, busy=0.
- IDLE:
  - If req!=0, pick a winner round-robin, searching from index rr_ptr upward with wrap.
  - Register gnt=onehot(winner), cnt=0 and go to GRANT on the next edge. Arbitration latency is 1 cycle.
  - If req=0, stay in IDLE.
- GRANT, with g = granted index:
  - rd_valid[g] = ~rempty. All other rd_valid bits are 0.
  - xfer = ~rempty & rd_ready[g]. rinc = xfer, combinational.
  - rinc is never asserted while rempty=1. rinc is never asserted outside GRANT.
  - On xfer: cnt <= cnt+1.
- Release to IDLE (gnt<=0, rr_ptr<=(g+1) mod NREQ) on either condition:
  - xfer with cnt==BURST-1 (burst complete), or
  - req[g]==0 and no xfer in that cycle (consumer withdrew).
  - If req[g] drops in a cycle that has an xfer, that word still transfers. Release happens on the same edge.
- Empty during GRANT: the grant is held while req[g]=1. cnt is frozen and no release happens. Streaming resumes when rempty falls.
- At least one IDLE cycle separates consecutive grants. A continuous single requester therefore sees BURST words, then a 1-cycle bubble, then the next burst.
- rd_data = rdata at all times. Consumers qualify it with rd_valid.
- gnt is always one-hot or zero. Requests arriving during GRANT are ignored until the next IDLE.
- cnt width = clog2(BURST)+1. It never exceeds BURST-1 when read.
- A synchronous rrst mid-burst forces IDLE on the next edge. Any word not popped stays in the FIFO.

Optional Feature:
- Macro: FIFO_RD_ARB_FIXED_PRIO_EN.
- Defined: IDLE picks the lowest set req index (index 0 highest priority). rr_ptr is neither used nor updated. Bursts and release rules are unchanged.
- Undefined: round-robin as above.

Decomposition:
- Shared package fifo_arb_pkg holds:
  - state encoding (IDLE, GRANT);
  - clog2 helper function;
  - default BURST/NREQ constants, reused by a future write-side arbiter.
- One sub-module, rr_pick: combinational rotating-priority picker.
  - Inputs: req, ptr.
  - Outputs: one-hot winner, any flag.
  - Fixed-priority mode ties ptr to 0.

Test Plan:
1. Single requester, FIFO holds 10 words, req[1]=1, rd_ready[1]=1 throughout -> gnt=0010 one cycle after req. Four rinc pulses, 1 IDLE cycle, four more, IDLE, two more. 10 words in order, then the grant is held with rinc=0 while empty.
2. All four req high, FIFO continuously non-empty, ready=1 -> grant order 0,1,2,3,0. Exactly 4 words each, one bubble between grants.
3. Grantee ready toggles 1,0,1,0 with FIFO non-empty -> rinc only in ready cycles. 4 words take 7 cycles. Data order is preserved.
4. FIFO goes empty after the 2nd word of a burst, refills 5 cycles later -> rinc=0 and rd_valid=0 while empty, no grant change. Burst completes with words 3-4.
5. req[2] drops mid-burst after 1 word, req[3] pending -> release. gnt=0 for one cycle, then gnt=1000. rr_ptr=3 honoured.
6. rrst asserted mid-burst for 1 cycle -> all outputs 0 after that edge. Next grant starts from index 0. Build with FIFO_RD_ARB_FIXED_PRIO_EN and req=1010 repeatedly -> index 1 always wins.
